// File: rtl/usb_wb_arbiter_pkg.sv
// Shared definitions for the usb core wishbone arbiter: bus field widths and
// the arbiter state encoding.
package usb_wb_arbiter_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/usb_rr_pick.sv
// Combinational round-robin picker: first set request bit strictly after ptr,
// scanning upward with wrap, so the port at ptr itself has lowest priority.
module usb_rr_pick #(
    parameter int N_PORTS = 2,
    localparam int IDX_W  = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               valid
);

    int               idx;
    logic [IDX_W-1:0] sel;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        sel   = '0;
        // Walk from farthest to nearest so the nearest requester is written last.
        for (int i = N_PORTS; i >= 1; i--) begin
            idx = (int'(ptr) + i) % N_PORTS;
            sel = IDX_W'(idx);
            if (req[sel]) begin
                grant = sel;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_wb_arbiter.sv
// Round-robin arbiter sharing the usb core wishbone port between N_PORTS
// requesters, one transaction in flight, with a watchdog on a missing ack.
module usb_wb_arbiter
    import usb_wb_arbiter_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PORTS*ADDR_W-1:0] rq_addr,
    input  logic [N_PORTS*DATA_W-1:0] rq_wdata,
    input  logic [N_PORTS-1:0]        rq_we,
    input  logic [N_PORTS-1:0]        rq_cyc,
    output logic [N_PORTS-1:0]        rq_ack,
    output logic [N_PORTS-1:0]        rq_err,
    output logic [DATA_W-1:0]         rq_rdata,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic [DATA_W-1:0]         wb_wdata,
    output logic                      wb_we,
    output logic                      wb_cyc,
    input  logic [DATA_W-1:0]         wb_rdata,
    input  logic                      wb_ack
);

    localparam int IDX_W = $clog2(N_PORTS);
    localparam int CNT_W = $clog2(TIMEOUT);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic [CNT_W-1:0] cnt;
    logic             dropped;
    logic             live;

    usb_rr_pick #(.N_PORTS(N_PORTS)) u_pick (
        .req   (rq_cyc),
        .ptr   (ptr),
        .grant (pick_idx),
        .valid (pick_vld)
    );

    // A requester that let go of rq_cyc at any point in GRANT gets no response.
    assign live = rq_cyc[gnt] & ~dropped;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= IDX_W'(N_PORTS - 1);
            gnt      <= '0;
            cnt      <= '0;
            dropped  <= 1'b0;
            wb_addr  <= '0;
            wb_wdata <= '0;
            wb_we    <= 1'b0;
            wb_cyc   <= 1'b0;
            rq_ack   <= '0;
            rq_err   <= '0;
            rq_rdata <= '0;
        end else begin
            rq_ack   <= '0;
            rq_err   <= '0;
            rq_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        gnt      <= pick_idx;
                        ptr      <= pick_idx;
                        wb_addr  <= ADDR_W'(rq_addr >> (int'(pick_idx) * ADDR_W));
                        wb_wdata <= DATA_W'(rq_wdata >> (int'(pick_idx) * DATA_W));
                        wb_we    <= rq_we[pick_idx];
                        wb_cyc   <= 1'b1;
                        cnt      <= '0;
                        dropped  <= 1'b0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    cnt <= cnt + 1'b1;
                    if (!rq_cyc[gnt]) begin
                        dropped <= 1'b1;
                    end
                    // A late ack on the watchdog's last cycle still counts as success.
                    if (wb_ack) begin
                        wb_cyc <= 1'b0;
                        state  <= ST_TURN;
                        if (live) begin
                            rq_ack[gnt] <= 1'b1;
                            rq_rdata    <= wb_we ? '0 : wb_rdata;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        wb_cyc <= 1'b0;
                        state  <= ST_TURN;
                        if (live) begin
                            rq_err[gnt] <= 1'b1;
                        end
                    end
                end
                ST_TURN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    wb_cyc <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_wb_arbiter.sv
// Bench for usb_wb_arbiter: directed corner cases, then randomized traffic
// checked against a transaction-level round-robin model.
module tb_usb_wb_arbiter;

    localparam int N       = 3;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*12-1:0]   rq_addr;
    logic [N*16-1:0]   rq_wdata;
    logic [N-1:0]      rq_we;
    logic [N-1:0]      rq_cyc;
    logic [N-1:0]      rq_ack;
    logic [N-1:0]      rq_err;
    logic [15:0]       rq_rdata;
    logic [11:0]       wb_addr;
    logic [15:0]       wb_wdata;
    logic              wb_we;
    logic              wb_cyc;
    logic [15:0]       wb_rdata;
    logic              wb_ack;

    int vectors = 0;
    int errors  = 0;

    usb_wb_arbiter #(.N_PORTS(N), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .rq_addr  (rq_addr),
        .rq_wdata (rq_wdata),
        .rq_we    (rq_we),
        .rq_cyc   (rq_cyc),
        .rq_ack   (rq_ack),
        .rq_err   (rq_err),
        .rq_rdata (rq_rdata),
        .wb_addr  (wb_addr),
        .wb_wdata (wb_wdata),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_rdata (wb_rdata),
        .wb_ack   (wb_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        rq_cyc = '0;
        wb_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Spec rule: first requester after the last granted port, upward with wrap.
    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= N; i++) begin
            if (req[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    // Random-phase model state
    logic [11:0] m_addr [N];
    logic [15:0] m_wd   [N];
    logic        m_we   [N];
    logic [N-1:0] pend, pend_s;
    logic [15:0] rdat;
    int  lp, g, wait_left, free_wait, k, p;
    bit  active, exp_grant, exp_done;

    initial begin
        rst = 1'b1; rq_addr = '0; rq_wdata = '0; rq_we = '0; rq_cyc = '0;
        wb_rdata = '0; wb_ack = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_cyc", 32'(wb_cyc), 0);
        chk("rst_addr", 32'(wb_addr), 0);
        chk("rst_ack", 32'(rq_ack), 0);
        chk("rst_err", 32'(rq_err), 0);
        chk("rst_rdata", 32'(rq_rdata), 0);
        rst = 1'b0;

        // Single read from port 0, core acks one cycle after seeing cyc
        rq_addr[0+:12] = 12'h000; rq_we = '0; rq_cyc = 3'b001;
        tick();
        chk("t1_cyc", 32'(wb_cyc), 1);
        chk("t1_addr", 32'(wb_addr), 32'h000);
        tick();
        chk("t1_noack_yet", 32'(rq_ack), 0);
        wb_ack = 1'b1; wb_rdata = 16'h8042;
        tick();
        wb_ack = 1'b0; rq_cyc = '0;
        chk("t1_ack", 32'(rq_ack), 32'b001);
        chk("t1_rdata", 32'(rq_rdata), 32'h8042);
        chk("t1_cyc_off", 32'(wb_cyc), 0);
        tick();
        chk("t1_rdata_clr", 32'(rq_rdata), 0);
        chk("t1_ack_clr", 32'(rq_ack), 0);

        // Ports 0 and 1 each hold rq_cyc for four writes: alternating grants
        do_reset();
        rq_addr[0+:12] = 12'h100; rq_addr[12+:12] = 12'h110;
        rq_we = 3'b011; rq_cyc = 3'b011;
        for (int t = 0; t < 8; t++) begin
            k = 0;
            while (wb_cyc !== 1'b1 && k < 20) begin tick(); k++; end
            chk("t2_grant_to", 32'(wb_cyc), 1);
            chk("t2_addr", 32'(wb_addr), 32'h100 + 32'((t % 2) * 16 + t / 2));
            chk("t2_we", 32'(wb_we), 1);
            wb_ack = 1'b1;
            tick();
            wb_ack = 1'b0;
            chk("t2_ack", 32'(rq_ack), 32'(1) << (t % 2));
            if (t / 2 < 3) rq_addr[(t % 2) * 12 +: 12] = 12'(12'h101 + (t % 2) * 16 + t / 2);
            else rq_cyc[t % 2] = 1'b0;
            tick();
            chk("t2_gap", 32'(wb_cyc), 0);
        end
        rq_cyc = '0;

        // EP status read held for four cycles: address stable, ack one cycle late
        do_reset();
        rq_addr[0+:12] = 12'h805; rq_we = '0; rq_cyc = 3'b001;
        tick();
        rq_addr[0+:12] = 12'h3C3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_addr_hold", 32'(wb_addr), 32'h805);
            chk("t3_no_ack", 32'(rq_ack), 0);
        end
        wb_ack = 1'b1; wb_rdata = 16'h5A5A;
        tick();
        wb_ack = 1'b0; rq_cyc = '0;
        chk("t3_ack", 32'(rq_ack), 32'b001);
        chk("t3_rdata", 32'(rq_rdata), 32'h5A5A);

        // Watchdog abort, then next port, then ack on the watchdog's last cycle
        do_reset();
        rq_addr[0+:12] = 12'h010; rq_addr[12+:12] = 12'h020;
        rq_we = 3'b011; rq_cyc = 3'b011;
        tick();
        chk("t4_cyc", 32'(wb_cyc), 1);
        chk("t4_addr0", 32'(wb_addr), 32'h010);
        k = 0;
        while (rq_err === '0 && k < TIMEOUT + 8) begin tick(); k++; end
        chk("t4_err_lat", 32'(k), 32'(TIMEOUT));
        chk("t4_err", 32'(rq_err), 32'b001);
        chk("t4_err_cyc", 32'(wb_cyc), 0);
        chk("t4_err_noack", 32'(rq_ack), 0);
        rq_cyc[0] = 1'b0;
        tick();
        chk("t4_turn", 32'(wb_cyc), 0);
        tick();
        chk("t4_next", 32'(wb_cyc), 1);
        chk("t4_addr1", 32'(wb_addr), 32'h020);
        repeat (TIMEOUT - 1) tick();
        chk("t4_pre_cyc", 32'(wb_cyc), 1);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0; rq_cyc = '0;
        chk("t4_coinc_ack", 32'(rq_ack), 32'b010);
        chk("t4_coinc_err", 32'(rq_err), 0);

        // Requester drops mid-GRANT, then reset mid-GRANT
        do_reset();
        rq_addr[12+:12] = 12'h805; rq_we = '0; rq_cyc = 3'b010;
        tick();
        chk("t5_gnt", 32'(wb_cyc), 1);
        chk("t5_addr", 32'(wb_addr), 32'h805);
        rq_cyc = '0;
        tick();
        wb_ack = 1'b1; wb_rdata = 16'h1234;
        tick();
        wb_ack = 1'b0;
        chk("t5_noack", 32'(rq_ack), 0);
        chk("t5_rdata0", 32'(rq_rdata), 0);
        chk("t5_done", 32'(wb_cyc), 0);
        tick(); tick();
        rq_cyc = 3'b010;
        tick();
        chk("t5_gnt2", 32'(wb_cyc), 1);
        rq_addr[0+:12] = 12'h0AA; rq_cyc = 3'b011; rst = 1'b1; wb_ack = 1'b1;
        tick();
        rst = 1'b0; wb_ack = 1'b0;
        chk("t5_rst_cyc", 32'(wb_cyc), 0);
        chk("t5_rst_ack", 32'(rq_ack), 0);
        tick();
        chk("t5_after_cyc", 32'(wb_cyc), 1);
        chk("t5_after_addr", 32'(wb_addr), 32'h0AA);

        // Randomized traffic against the transaction-level model
        do_reset();
        lp = N - 1; active = 0; free_wait = 0; pend = '0; g = 0; wait_left = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int q = 0; q < N; q++) begin
                if (!pend[q] && $urandom_range(3) == 0) begin
                    pend[q]   = 1'b1;
                    m_addr[q] = 12'($urandom);
                    m_wd[q]   = 16'($urandom);
                    m_we[q]   = 1'($urandom);
                end
                rq_addr[q*12 +: 12]  = m_addr[q];
                rq_wdata[q*16 +: 16] = m_wd[q];
                rq_we[q]             = m_we[q];
            end
            rq_cyc = pend;
            if (active) begin
                rq_addr[g*12 +: 12]  = 12'($urandom);
                rq_wdata[g*16 +: 16] = 16'($urandom);
                rq_we[g]             = 1'($urandom);
                wb_ack = (wait_left == 0);
            end else begin
                wb_ack = ($urandom_range(2) == 0);
            end
            rdat = 16'($urandom);
            wb_rdata = rdat;
            exp_grant = !active && free_wait == 0 && pend != '0;
            exp_done  = active && wait_left == 0;
            pend_s = pend;
            tick();
            if (exp_grant) begin
                p = rr_pick(pend_s, lp);
                chk("r_grant_cyc", 32'(wb_cyc), 1);
                chk("r_grant_addr", 32'(wb_addr), 32'(m_addr[p]));
                chk("r_grant_wdata", 32'(wb_wdata), 32'(m_wd[p]));
                chk("r_grant_we", 32'(wb_we), 32'(m_we[p]));
                chk("r_grant_ack", 32'(rq_ack), 0);
                active = 1; g = p; lp = p; wait_left = $urandom_range(4);
            end else if (exp_done) begin
                chk("r_ack", 32'(rq_ack), 32'(1) << g);
                chk("r_rdata", 32'(rq_rdata), m_we[g] ? 32'h0 : 32'(rdat));
                chk("r_done_err", 32'(rq_err), 0);
                chk("r_done_cyc", 32'(wb_cyc), 0);
                active = 0; pend[g] = 1'b0; free_wait = 1;
            end else begin
                chk("r_idle_ack", 32'(rq_ack), 0);
                chk("r_idle_err", 32'(rq_err), 0);
                chk("r_idle_rdata", 32'(rq_rdata), 0);
                chk("r_cyc", 32'(wb_cyc), 32'(active));
                if (active) begin
                    chk("r_addr_hold", 32'(wb_addr), 32'(m_addr[g]));
                    wait_left--;
                end else if (free_wait > 0) begin
                    free_wait--;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
